// File: rtl/life_pkg.sv
// Shared types and constants for the Game-of-Life grid engine.
package life_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      STATUS_COMPLETE = 2'd0,
      STATUS_EXTINCT  = 2'd1,
      STATUS_STABLE   = 2'd2
   } status_e;

   // Classic Conway rule B3/S23 as neighbour-count masks.
   localparam logic [8:0] BIRTH_B3    = 9'h008;
   localparam logic [8:0] SURVIVE_S23 = 9'h00C;

   // Number of live neighbours, 0..8, so 4 bits never overflow.
   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] c;
      c = '0;
      for (int k = 0; k < 8; k++) begin
         c = c + {3'b000, v[k]};
      end
      return c;
   endfunction

endpackage

// File: rtl/life_rule_cell.sv
// One cell of the grid: applies the programmable birth/survival rule
// to the cell's own state and its eight neighbours.
module life_rule_cell
   import life_pkg::*;
(
   input  logic       self,
   input  logic [7:0] n,
   input  logic [8:0] birth_mask,
   input  logic [8:0] survive_mask,
   output logic       next
);

   logic [3:0] count;

   assign count = popcount8(n);
   assign next  = self ? survive_mask[count] : birth_mask[count];

endmodule

// File: rtl/life_grid.sv
// Game-of-Life grid engine: register-held WIDTH x HEIGHT grid advanced one
// generation per clock, with programmable rules, toroidal or dead edges,
// and early termination on extinction or still life.
module life_grid
   import life_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int HEIGHT = 8,
   parameter int WRAP   = 1,
   parameter int GEN_W  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [$clog2(HEIGHT)-1:0] wr_row,
   input  logic [WIDTH-1:0]          wr_data,
   input  logic [$clog2(HEIGHT)-1:0] rd_row,
   output logic [WIDTH-1:0]          rd_data,
   input  logic                      start,
   input  logic [GEN_W-1:0]          num_gens,
   input  logic [8:0]                birth_mask,
   input  logic [8:0]                survive_mask,
   output logic                      busy,
   output logic                      done,
   output logic [1:0]                status,
   output logic [GEN_W-1:0]          gen_count
);

   localparam int ROW_W = $clog2(HEIGHT);
   // Row count widened by one bit so out-of-range indices compare cleanly.
   localparam logic [ROW_W:0] ROWS = (ROW_W + 1)'(HEIGHT);

   logic [HEIGHT-1:0][WIDTH-1:0] grid_q;
   logic [HEIGHT-1:0][WIDTH-1:0] next_grid_d;
   state_e                       state_q;
   status_e                      status_q;
   logic                         busy_q;
   logic                         done_q;
   logic [GEN_W-1:0]             gen_count_q;
   logic [GEN_W-1:0]             num_gens_q;
   logic [8:0]                   birth_q;
   logic [8:0]                   survive_q;
   logic [WIDTH-1:0]             rd_data_q;
   logic [GEN_W-1:0]             gen_inc_d;
   logic                         grid_same_d;
   logic                         next_zero_d;

   // Neighbour gathering: edge rows/columns either wrap or read as dead.
   for (genvar gi = 0; gi < HEIGHT; gi++) begin : g_row
      localparam int RU   = (gi == 0) ? HEIGHT - 1 : gi - 1;
      localparam int RD   = (gi == HEIGHT - 1) ? 0 : gi + 1;
      localparam bit U_OK = (WRAP != 0) || (gi != 0);
      localparam bit D_OK = (WRAP != 0) || (gi != HEIGHT - 1);

      logic [WIDTH-1:0] up_row;
      logic [WIDTH-1:0] mid_row;
      logic [WIDTH-1:0] dn_row;

      assign up_row  = U_OK ? grid_q[RU] : '0;
      assign mid_row = grid_q[gi];
      assign dn_row  = D_OK ? grid_q[RD] : '0;

      for (genvar gj = 0; gj < WIDTH; gj++) begin : g_col
         localparam int CL   = (gj == 0) ? WIDTH - 1 : gj - 1;
         localparam int CR   = (gj == WIDTH - 1) ? 0 : gj + 1;
         localparam bit L_OK = (WRAP != 0) || (gj != 0);
         localparam bit R_OK = (WRAP != 0) || (gj != WIDTH - 1);

         logic [7:0] nbr;

         assign nbr = {up_row[CL] & L_OK,  up_row[gj], up_row[CR] & R_OK,
                       mid_row[CL] & L_OK, mid_row[CR] & R_OK,
                       dn_row[CL] & L_OK,  dn_row[gj], dn_row[CR] & R_OK};

         life_rule_cell u_cell (
            .self         (mid_row[gj]),
            .n            (nbr),
            .birth_mask   (birth_q),
            .survive_mask (survive_q),
            .next         (next_grid_d[gi][gj])
         );
      end
   end

   assign grid_same_d = (next_grid_d == grid_q);
   assign next_zero_d = (next_grid_d == '0);
   assign gen_inc_d   = gen_count_q + GEN_W'(1);

   // Control FSM, grid storage, host write port and registered readback.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         status_q    <= STATUS_COMPLETE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         gen_count_q <= '0;
         num_gens_q  <= '0;
         birth_q     <= BIRTH_B3;
         survive_q   <= SURVIVE_S23;
         grid_q      <= '0;
         rd_data_q   <= '0;
      end else begin
         done_q    <= 1'b0;
         rd_data_q <= ({1'b0, rd_row} < ROWS) ? grid_q[rd_row] : '0;
         case (state_q)
            ST_IDLE: begin
               if (wr_en && ({1'b0, wr_row} < ROWS)) begin
                  grid_q[wr_row] <= wr_data;
               end
               if (start) begin
                  num_gens_q  <= num_gens;
                  birth_q     <= birth_mask;
                  survive_q   <= survive_mask;
                  gen_count_q <= '0;
                  if (num_gens == '0) begin
                     // Nothing to do: report completion without touching the grid.
                     done_q   <= 1'b1;
                     status_q <= STATUS_COMPLETE;
                  end else begin
                     state_q <= ST_RUN;
                     busy_q  <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (grid_same_d) begin
                  // Still life: the generation that would repeat is not counted.
                  status_q <= STATUS_STABLE;
                  state_q  <= ST_IDLE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
               end else begin
                  grid_q      <= next_grid_d;
                  gen_count_q <= gen_inc_d;
                  if (next_zero_d) begin
                     status_q <= STATUS_EXTINCT;
                     state_q  <= ST_IDLE;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                  end else if (gen_inc_d == num_gens_q) begin
                     status_q <= STATUS_COMPLETE;
                     state_q  <= ST_IDLE;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign rd_data   = rd_data_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign status    = status_q;
   assign gen_count = gen_count_q;

endmodule

// File: tb/tb_life_grid.sv
// Bench for life_grid: a toroidal and a dead-border instance share stimulus;
// a reference model pushes expected run results to per-instance queues that
// are popped when each instance pulses done.
module tb_life_grid;

   typedef logic [7:0][7:0] grid_t;

   typedef struct {
      logic [1:0]  status;
      logic [15:0] gens;
      int          lat;
      grid_t       grid;
   } exp_t;

   localparam logic [8:0] B3  = 9'h008;
   localparam logic [8:0] S23 = 9'h00C;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [2:0]  wr_row;
   logic [7:0]  wr_data;
   logic [2:0]  rd_row;
   logic        start;
   logic [15:0] num_gens;
   logic [8:0]  birth_mask;
   logic [8:0]  survive_mask;

   logic [7:0]  rd_o   [2];
   logic        busy_o [2];
   logic        done_o [2];
   logic [1:0]  stat_o [2];
   logic [15:0] gen_o  [2];

   int          total = 0;
   int          bad   = 0;
   grid_t       mg [2];
   logic [7:0]  rb [2][8];
   exp_t        q_wrap [$];
   exp_t        q_dead [$];

   always #5 clk = ~clk;

   life_grid #(.WIDTH(8), .HEIGHT(8), .WRAP(1), .GEN_W(16)) dut_wrap (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
      .rd_row(rd_row), .rd_data(rd_o[0]), .start(start), .num_gens(num_gens),
      .birth_mask(birth_mask), .survive_mask(survive_mask), .busy(busy_o[0]),
      .done(done_o[0]), .status(stat_o[0]), .gen_count(gen_o[0])
   );

   life_grid #(.WIDTH(8), .HEIGHT(8), .WRAP(0), .GEN_W(16)) dut_dead (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
      .rd_row(rd_row), .rd_data(rd_o[1]), .start(start), .num_gens(num_gens),
      .birth_mask(birth_mask), .survive_mask(survive_mask), .busy(busy_o[1]),
      .done(done_o[1]), .status(stat_o[1]), .gen_count(gen_o[1])
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic grid_t model_step(grid_t g, logic [8:0] b, logic [8:0] s, bit wrap);
      grid_t nx;
      int cnt, rr, cc;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  if (dr == 0 && dc == 0) continue;
                  rr = r + dr;
                  cc = c + dc;
                  if (wrap) begin
                     rr = (rr + 8) % 8;
                     cc = (cc + 8) % 8;
                  end else if (rr < 0 || rr > 7 || cc < 0 || cc > 7) begin
                     continue;
                  end
                  cnt += int'(g[rr][cc]);
               end
            end
            nx[r][c] = g[r][c] ? s[cnt] : b[cnt];
         end
      end
      return nx;
   endfunction

   // Expected status, generation count, done latency (edges after start) and final grid.
   function automatic exp_t model_run(grid_t g, logic [15:0] n, logic [8:0] b, logic [8:0] s, bit wrap);
      exp_t e;
      grid_t nx;
      e.gens = '0;
      e.grid = g;
      if (n == 0) begin
         e.status = 2'd0;
         e.lat    = 0;
         return e;
      end
      while (1) begin
         nx = model_step(e.grid, b, s, wrap);
         if (nx == e.grid) begin
            e.status = 2'd2;
            e.lat    = int'(e.gens) + 1;
            break;
         end
         e.grid = nx;
         e.gens = e.gens + 16'd1;
         if (nx == '0) begin
            e.status = 2'd1;
            e.lat    = int'(e.gens);
            break;
         end
         if (e.gens == n) begin
            e.status = 2'd0;
            e.lat    = int'(e.gens);
            break;
         end
      end
      return e;
   endfunction

   task automatic load(input grid_t g);
      for (int r = 0; r < 8; r++) begin
         wr_en   = 1'b1;
         wr_row  = 3'(r);
         wr_data = g[r];
         @(negedge clk);
      end
      wr_en = 1'b0;
      mg[0] = g;
      mg[1] = g;
   endtask

   task automatic readback(input string name);
      for (int r = 0; r < 8; r++) begin
         rd_row = 3'(r);
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            check_val($sformatf("%s_row%0d_i%0d", name, r, k), rd_o[k], mg[k][r]);
            rb[k][r] = rd_o[k];
         end
      end
   endtask

   task automatic run_gens(input string name, input logic [15:0] n, input logic [8:0] bm,
                           input logic [8:0] sm, input bit inject);
      exp_t e;
      bit   fin [2];
      int   obs [2];
      int   cyc;
      for (int k = 0; k < 2; k++) begin
         e = model_run(mg[k], n, bm, sm, k == 0);
         mg[k] = e.grid;
         if (k == 0) q_wrap.push_back(e);
         else        q_dead.push_back(e);
         fin[k] = 1'b0;
         obs[k] = 0;
      end
      num_gens     = n;
      birth_mask   = bm;
      survive_mask = sm;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 0;
      for (int k = 0; k < 2; k++) begin
         check_val($sformatf("%s_busy_i%0d", name, k), busy_o[k], (n != 0));
      end
      while (1) begin
         for (int k = 0; k < 2; k++) begin
            if (!fin[k] && done_o[k]) begin
               fin[k] = 1'b1;
               obs[k] = cyc;
               e = (k == 0) ? q_wrap.pop_front() : q_dead.pop_front();
               check_val($sformatf("%s_status_i%0d", name, k), stat_o[k], e.status);
               check_val($sformatf("%s_gens_i%0d", name, k), gen_o[k], e.gens);
               check_val($sformatf("%s_lat_i%0d", name, k), obs[k], e.lat);
               check_val($sformatf("%s_busyend_i%0d", name, k), busy_o[k], 1'b0);
            end else if (fin[k] && cyc == obs[k] + 1) begin
               check_val($sformatf("%s_donedrop_i%0d", name, k), done_o[k], 1'b0);
            end
         end
         if ((fin[0] && fin[1] && cyc > obs[0] && cyc > obs[1]) || cyc >= 300) break;
         if (inject && cyc == 2) begin
            // Host pokes while busy: both must be ignored.
            wr_en    = 1'b1;
            wr_row   = 3'd0;
            wr_data  = 8'hFF;
            start    = 1'b1;
            num_gens = 16'd1;
         end else begin
            wr_en = 1'b0;
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      wr_en = 1'b0;
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         check_val($sformatf("%s_timeout_i%0d", name, k), fin[k], 1'b1);
         if (!fin[k]) begin
            if (k == 0) void'(q_wrap.pop_front());
            else        void'(q_dead.pop_front());
         end
      end
      readback(name);
      $display("run %s n=%0d: wrap status=%0d gens=%0d lat=%0d | dead status=%0d gens=%0d lat=%0d",
               name, n, stat_o[0], gen_o[0], obs[0], stat_o[1], gen_o[1], obs[1]);
   endtask

   initial begin
      grid_t blinker, block, single, glider, b36;
      bit    seen;

      blinker = '0; blinker[3] = 8'h1C;
      block   = '0; block[3] = 8'h18; block[4] = 8'h18;
      single  = '0; single[0] = 8'h01;
      glider  = '0; glider[0] = 8'h02; glider[1] = 8'h04; glider[2] = 8'h07;
      b36     = '0; b36[2] = 8'h07; b36[4] = 8'h07;

      rst = 1'b1; wr_en = 1'b0; wr_row = '0; wr_data = '0; rd_row = '0;
      start = 1'b0; num_gens = '0; birth_mask = B3; survive_mask = S23;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      mg[0] = '0;
      mg[1] = '0;
      for (int k = 0; k < 2; k++) begin
         check_val($sformatf("rst_busy_i%0d", k), busy_o[k], 1'b0);
         check_val($sformatf("rst_done_i%0d", k), done_o[k], 1'b0);
         check_val($sformatf("rst_status_i%0d", k), stat_o[k], 2'd0);
         check_val($sformatf("rst_gens_i%0d", k), gen_o[k], 16'd0);
      end
      readback("rst");

      load(blinker);
      run_gens("blink1", 16'd1, B3, S23, 1'b0);
      for (int r = 2; r <= 4; r++) check_val($sformatf("blink1_vert_r%0d", r), rb[0][r], 8'h08);

      load(blinker);
      run_gens("blink2", 16'd2, B3, S23, 1'b0);
      check_val("blink2_home", rb[0][3], 8'h1C);

      run_gens("zero", 16'd0, B3, S23, 1'b0);

      load(block);
      run_gens("block", 16'd5, B3, S23, 1'b0);
      check_val("block_stable", stat_o[0], 2'd2);

      load(single);
      run_gens("single", 16'd5, B3, S23, 1'b0);
      check_val("single_extinct", stat_o[0], 2'd1);

      load(glider);
      run_gens("glider", 16'd32, B3, S23, 1'b0);
      for (int r = 0; r < 8; r++) check_val($sformatf("glider_home_r%0d", r), rb[0][r], glider[r]);

      load(b36);
      run_gens("b36", 16'd1, 9'h048, S23, 1'b0);
      check_val("b36_born", rb[0][3][1], 1'b1);

      load(blinker);
      run_gens("busy_ign", 16'd20, B3, S23, 1'b1);

      // Abort a run with reset after the third generation.
      load(blinker);
      num_gens = 16'd20; birth_mask = B3; survive_mask = S23; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check_val("midrst_gen3", gen_o[0], 16'd3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mg[0] = '0;
      mg[1] = '0;
      seen  = 1'b0;
      for (int k = 0; k < 2; k++) begin
         check_val($sformatf("midrst_busy_i%0d", k), busy_o[k], 1'b0);
         check_val($sformatf("midrst_gens_i%0d", k), gen_o[k], 16'd0);
         check_val($sformatf("midrst_status_i%0d", k), stat_o[k], 2'd0);
      end
      for (int c = 0; c < 12; c++) begin
         seen = seen | done_o[0] | done_o[1];
         @(negedge clk);
      end
      check_val("midrst_nodone", seen, 1'b0);
      readback("midrst");
      $display("run midrst: aborted at generation 3");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
